// File: rtl/reg_ctrl_pkg.sv
// Shared types for the register-transfer sequencer: op encodings, FSM states and the
// queued command record.
package reg_ctrl_pkg;

  localparam int unsigned IDX_W        = 3;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_ACC_IDX  = 7;

  typedef enum logic [1:0] {
    OP_MOV      = 2'b00,
    OP_LOAD_ACC = 2'b01,
    OP_READ     = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StLatch,
    StResp
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
  } cmd_t;

endpackage

// File: rtl/reg_cmd_fifo.sv
// Small synchronous command queue with async reset; a push into a full queue is taken
// when a pop happens in the same cycle.
module reg_cmd_fifo
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-file transfer sequencer driving one-hot read/write strobes on cpu_bus.
// Define REG_XFER_STATS_EN to build the saturating done/err counters.
module reg_xfer_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
  parameter int unsigned ACC_IDX       = DEF_ACC_IDX,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_W-1:0]    cmd_src,
  input  logic [IDX_W-1:0]    cmd_dst,
  output logic [NUM_REGS-1:0] read_en,
  output logic [NUM_REGS-1:0] write_en,
  output logic                bus_valid,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         xfer_count,
  output logic [7:0]          err_count
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] ACC        = IDX_W'(ACC_IDX);

  state_e           state_q;
  op_e              cur_op_q;
  logic [IDX_W-1:0] cur_dst_q;
  logic [3:0]       settle_q;

  cmd_t fifo_in;
  cmd_t fifo_head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  logic src_ok;
  logic dst_ok;
  logic go_drive;
  logic go_latch;
  logic head_ok;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  assign fifo_in  = '{op: op_e'(cmd_op), src: cmd_src, dst: cmd_dst};
  assign fifo_pop = (state_q == StIdle) && !fifo_empty;
  // A full queue still accepts when the FSM pops its head in the same cycle.
  assign cmd_ready = !fifo_full || fifo_pop;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  reg_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (cmd_valid && cmd_ready),
    .wdata(fifo_in),
    .pop  (fifo_pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign src_ok = 32'(fifo_head.src) < NUM_REGS;
  assign dst_ok = 32'(fifo_head.dst) < NUM_REGS;

  // Classify the head command; anything not driven or latched completes in RESP.
  always_comb begin
    go_drive = 1'b0;
    go_latch = 1'b0;
    head_ok  = 1'b0;
    case (fifo_head.op)
      OP_MOV: begin
        if (src_ok && dst_ok && fifo_head.dst != ACC) begin
          if (fifo_head.src == fifo_head.dst) begin
            head_ok = 1'b1;
          end else begin
            go_drive = 1'b1;
            head_ok  = 1'b1;
          end
        end
      end
      OP_LOAD_ACC: begin
        go_latch = 1'b1;
        head_ok  = 1'b1;
      end
      OP_READ: begin
        go_drive = src_ok;
        head_ok  = src_ok;
      end
      default: head_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_op_q  <= OP_MOV;
      cur_dst_q <= '0;
      settle_q  <= '0;
      read_en   <= '0;
      write_en  <= '0;
      bus_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            cur_op_q  <= fifo_head.op;
            cur_dst_q <= fifo_head.dst;
            settle_q  <= '0;
            if (go_drive) begin
              read_en <= onehot(fifo_head.src);
              state_q <= StDrive;
            end else if (go_latch) begin
              write_en <= onehot(ACC);
              state_q  <= StLatch;
            end else begin
              done    <= head_ok;
              err     <= !head_ok;
              state_q <= StResp;
            end
          end
        end
        StDrive: begin
          if (settle_q != SETTLE_LAST) begin
            settle_q <= settle_q + 1'b1;
          end else if (cur_op_q == OP_READ) begin
            // READ spends one extra DRIVE cycle presenting bus_valid.
            if (bus_valid) begin
              read_en   <= '0;
              bus_valid <= 1'b0;
              done      <= 1'b1;
              state_q   <= StResp;
            end else begin
              bus_valid <= 1'b1;
            end
          end else begin
            write_en <= onehot(cur_dst_q);
            state_q  <= StLatch;
          end
        end
        StLatch: begin
          read_en  <= '0;
          write_en <= '0;
          done     <= 1'b1;
          state_q  <= StResp;
        end
        StResp: begin
          done    <= 1'b0;
          err     <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef REG_XFER_STATS_EN
  logic [15:0] xfer_count_q;
  logic [7:0]  err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      if (done && xfer_count_q != 16'hFFFF) begin
        xfer_count_q <= xfer_count_q + 1'b1;
      end
      if (err && err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign xfer_count = xfer_count_q;
  assign err_count  = err_count_q;
`else
  assign xfer_count = '0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl: one instance at SETTLE_CYCLES=1, one at 3.
module tb_reg_xfer_ctrl;
  import reg_ctrl_pkg::*;

`ifdef REG_XFER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       valid1, ready1, bv1, busy1, done1, err1;
  logic [1:0] op1;
  logic [2:0] src1, dst1;
  logic [7:0] re1, we1, ec1;
  logic [15:0] xc1;

  logic       valid3, ready3, bv3, busy3, done3, err3;
  logic [1:0] op3;
  logic [2:0] src3, dst3;
  logic [7:0] re3, we3, ec3;
  logic [15:0] xc3;

  reg_xfer_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(valid1), .cmd_ready(ready1), .cmd_op(op1),
    .cmd_src(src1), .cmd_dst(dst1), .read_en(re1), .write_en(we1), .bus_valid(bv1),
    .busy(busy1), .done(done1), .err(err1), .xfer_count(xc1), .err_count(ec1)
  );

  reg_xfer_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(valid3), .cmd_ready(ready3), .cmd_op(op3),
    .cmd_src(src3), .cmd_dst(dst3), .read_en(re3), .write_en(we3), .bus_valid(bv3),
    .busy(busy3), .done(done3), .err(err3), .xfer_count(xc3), .err_count(ec3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ready, let the accepting edge pass.
  task automatic send(input bit sel, input logic [1:0] op, input logic [2:0] s,
                      input logic [2:0] d);
    int n = 0;
    if (sel) begin
      valid3 = 1'b1; op3 = op; src3 = s; dst3 = d;
    end else begin
      valid1 = 1'b1; op1 = op; src1 = s; dst1 = d;
    end
    #1;
    while (!(sel ? ready3 : ready1) && n < 40) begin
      step();
      n++;
    end
    check("send_ready", sel ? ready3 : ready1, 1);
    step();
    valid1 = 1'b0;
    valid3 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("onehot_re1", $onehot0(re1), 1);
      check("onehot_we1", $onehot0(we1), 1);
      check("onehot_re3", $onehot0(re3), 1);
      check("onehot_we3", $onehot0(we3), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wexp [4];
    int acc, dones, wseen, drop_at;
    bit acc_now;

    wexp[0] = 8'h02; wexp[1] = 8'h04; wexp[2] = 8'h08; wexp[3] = 8'h10;
    reset = 1'b1;
    valid1 = 1'b0; op1 = '0; src1 = '0; dst1 = '0;
    valid3 = 1'b0; op3 = '0; src3 = '0; dst3 = '0;
    step();
    step();
    check("rst_read_en", re1, 0);
    check("rst_write_en", we1, 0);
    check("rst_bus_valid", bv1, 0);
    check("rst_done", done1, 0);
    check("rst_err", err1, 0);
    check("rst_busy", busy1, 0);
    check("rst_xfer_count", xc1, 0);
    check("rst_err_count", ec1, 0);
    reset = 1'b0;
    step();
    check("idle_ready", ready1, 1);

    // MOV 2 -> 5
    send(0, OP_MOV, 3'd2, 3'd5);
    check("mov_busy_queued", busy1, 1);
    check("mov_re_before_pop", re1, 0);
    step();
    check("mov_c1_re", re1, 8'h04);
    check("mov_c1_we", we1, 8'h00);
    check("mov_c1_done", done1, 0);
    step();
    check("mov_c2_re", re1, 8'h04);
    check("mov_c2_we", we1, 8'h20);
    check("mov_c2_done", done1, 0);
    step();
    check("mov_c3_re", re1, 8'h00);
    check("mov_c3_we", we1, 8'h00);
    check("mov_c3_done", done1, 1);
    check("mov_c3_err", err1, 0);
    step();
    check("mov_c4_done", done1, 0);
    check("mov_c4_busy", busy1, 0);

    // LOAD_ACC
    send(0, OP_LOAD_ACC, 3'd0, 3'd0);
    step();
    check("ld_c1_we", we1, 8'h80);
    check("ld_c1_re", re1, 8'h00);
    check("ld_c1_done", done1, 0);
    step();
    check("ld_c2_we", we1, 8'h00);
    check("ld_c2_done", done1, 1);
    step();
    check("ld_c3_done", done1, 0);

    // READ src 3
    send(0, OP_READ, 3'd3, 3'd0);
    step();
    check("rd_c1_re", re1, 8'h08);
    check("rd_c1_bv", bv1, 0);
    step();
    check("rd_c2_re", re1, 8'h08);
    check("rd_c2_bv", bv1, 1);
    check("rd_c2_we", we1, 8'h00);
    step();
    check("rd_c3_re", re1, 8'h00);
    check("rd_c3_bv", bv1, 0);
    check("rd_c3_done", done1, 1);
    step();

    // Illegal and no-op commands
    send(0, OP_RSVD, 3'd0, 3'd0);
    step();
    check("rsvd_err", err1, 1);
    check("rsvd_done", done1, 0);
    check("rsvd_re", re1, 0);
    check("rsvd_we", we1, 0);
    step();
    check("rsvd_err_clear", err1, 0);
    check("rsvd_err_count", ec1, Stats ? 1 : 0);
    send(0, OP_MOV, 3'd1, 3'd7);
    step();
    check("movacc_err", err1, 1);
    check("movacc_done", done1, 0);
    check("movacc_we", we1, 0);
    step();
    send(0, OP_MOV, 3'd4, 3'd4);
    step();
    check("noop_done", done1, 1);
    check("noop_err", err1, 0);
    check("noop_re", re1, 0);
    check("noop_we", we1, 0);
    step();
    check("pre_bp_xfer_count", xc1, Stats ? 4 : 0);
    check("pre_bp_err_count", ec1, Stats ? 2 : 0);

    // Backpressure: four MOVs with valid held high
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("bp_count_cleared", xc1, 0);
    acc = 0; dones = 0; wseen = 0; drop_at = -1;
    valid1 = 1'b1; op1 = OP_MOV; src1 = 3'd0; dst1 = 3'd1;
    #1;
    for (int cyc = 0; cyc < 60 && dones < 4; cyc++) begin
      acc_now = valid1 && ready1;
      if (!ready1 && drop_at < 0) drop_at = acc;
      step();
      if (acc_now) begin
        acc++;
        if (acc < 4) begin
          src1 = 3'(acc);
          dst1 = 3'(acc + 1);
        end else begin
          valid1 = 1'b0;
        end
      end
      if (we1 != 8'h00) begin
        if (wseen < 4) check("bp_write_order", we1, wexp[wseen]);
        wseen++;
      end
      if (done1) dones++;
      #1;
    end
    valid1 = 1'b0;
    check("bp_ready_drop_after", drop_at, 3);
    check("bp_accepted", acc, 4);
    check("bp_dones", dones, 4);
    check("bp_writes", wseen, 4);
    step();
    check("bp_xfer_count", xc1, Stats ? 4 : 0);
    check("bp_busy_end", busy1, 0);

    // Reset during LATCH of a MOV with one command queued
    send(0, OP_MOV, 3'd0, 3'd1);
    send(0, OP_MOV, 3'd2, 3'd3);
    check("rl_drive_re", re1, 8'h01);
    step();
    check("rl_latch_re", re1, 8'h01);
    check("rl_latch_we", we1, 8'h02);
    check("rl_latch_busy", busy1, 1);
    #1;
    reset = 1'b1;
    #1;
    check("rl_async_re", re1, 0);
    check("rl_async_we", we1, 0);
    check("rl_async_busy", busy1, 0);
    step();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rl_after_done", done1, 0);
      check("rl_after_busy", busy1, 0);
    end
    check("rl_after_ready", ready1, 1);

    // SETTLE_CYCLES=3 instance: MOV 2 -> 5
    send(1, OP_MOV, 3'd2, 3'd5);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("s3_re", re3, (k <= 4) ? 8'h04 : 8'h00);
      check("s3_we", we3, (k == 4) ? 8'h20 : 8'h00);
      check("s3_done", done3, (k == 5) ? 1 : 0);
    end
    step();
    check("s3_done_clear", done3, 0);
    check("s3_busy_end", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
